// File: rtl/count_seq_ctrl_if.sv
// Counter bundle between count_seq_ctrl (master) and the shared loadable up-counter (slave).
interface count_ifc #(
  parameter int W = 4
) ();
  logic [W-1:0] Q;
  logic [W-1:0] P;
  logic         Load;
  logic         Enable;
  logic         MR;

  modport master (input Q, output P, Load, Enable, MR);
  modport slave  (input P, Load, Enable, MR, output Q);
endinterface

// File: rtl/count_seq_ctrl.sv
// Two-requester scheduler/sequencer for the shared up-counter on count_ifc.
// Build option: define COUNT_SEQ_CTRL_FIXED_PRIO_EN to make requester 0 always win a tie.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and captures the start value
// LOAD  | drives Load/P with the captured value, pulses gnt[owner]
// RUN   | counts while Q != LIMIT
// DONE  | pulses done[owner] and clears the counter through MR
module count_seq_ctrl #(
  parameter int           W     = 4,
  parameter logic [W-1:0] LIMIT = {W{1'b1}}
) (
  input  logic         CLK,
  input  logic         MR_n,
  input  logic [1:0]   req,
  input  logic [W-1:0] start0,
  input  logic [W-1:0] start1,
  output logic [1:0]   gnt,
  output logic [1:0]   done,
  output logic         busy,
  count_ifc.master     cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic         owner_q, owner_d;
  logic [W-1:0] val_q,   val_d;
  logic         win;
`ifndef COUNT_SEQ_CTRL_FIXED_PRIO_EN
  logic         last_q,  last_d;
`endif

  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      val_q   <= '0;
`ifndef COUNT_SEQ_CTRL_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      val_q   <= val_d;
`ifndef COUNT_SEQ_CTRL_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    win = 1'b0;
    if (req == 2'b10) begin
      win = 1'b1;
    end else if (req == 2'b11) begin
`ifdef COUNT_SEQ_CTRL_FIXED_PRIO_EN
      win = 1'b0;
`else
      win = ~last_q;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    val_d      = val_q;
`ifndef COUNT_SEQ_CTRL_FIXED_PRIO_EN
    last_d     = last_q;
`endif
    gnt        = 2'b00;
    done       = 2'b00;
    busy       = (state_q != S_IDLE);
    cnt.P      = val_q;
    cnt.Load   = 1'b0;
    cnt.Enable = 1'b0;
    cnt.MR     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          owner_d = win;
          val_d   = win ? start1 : start0;
`ifndef COUNT_SEQ_CTRL_FIXED_PRIO_EN
          last_d  = win;
`endif
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt.Load = 1'b1;
        gnt      = owner_q ? 2'b10 : 2'b01;
        state_d  = S_RUN;
      end
      S_RUN: begin
        // Enable is the only path from Q into the outputs
        cnt.Enable = (cnt.Q != LIMIT);
        if (cnt.Q == LIMIT) state_d = S_DONE;
      end
      S_DONE: begin
        done    = owner_q ? 2'b10 : 2'b01;
        cnt.MR  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
